// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing generator: pixel/line counters, sync outputs delayed to
// match a registered renderer, and a vblank-aligned front/back buffer swap.
module vga_timing_gen #(
    parameter int unsigned SYNC_DLY     = 1,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 491,
    parameter int unsigned V_TOTAL      = 525
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic        swap_req,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        vblank_start,
    output logic [15:0] frame_count,
    output logic        front_buf,
    output logic        swap_ack
);
    localparam int unsigned CW           = 10;
    localparam int unsigned FW           = 16;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned H_SYNC_START = 656;
    localparam int unsigned H_SYNC_END   = 751;
    localparam int unsigned H_TOTAL      = 800;

    logic [CW-1:0] r_hcnt;
    logic [CW-1:0] r_vcnt;
    logic [FW-1:0] r_frame_cnt;
    logic          r_front;
    logic          r_pending;
    logic          r_ack;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_vblank_start;
    logic w_swap;

    assign w_h_wrap       = (r_hcnt == CW'(H_TOTAL - 1));
    assign w_v_wrap       = (r_vcnt == CW'(V_TOTAL - 1));
    assign w_hs_raw       = !((r_hcnt >= CW'(H_SYNC_START)) && (r_hcnt <= CW'(H_SYNC_END)));
    assign w_vs_raw       = !((r_vcnt >= CW'(V_SYNC_START)) && (r_vcnt <= CW'(V_SYNC_END)));
    assign w_vblank_start = (r_hcnt == '0) && (r_vcnt == CW'(V_ACTIVE));
    // A swap is taken only on the single vblank_start cycle of each frame.
    assign w_swap         = w_vblank_start && (r_pending || swap_req);

    // Pixel and line counters; lines advance only on horizontal wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_wrap ? '0 : r_vcnt + CW'(1);
        end else begin
            r_hcnt <= r_hcnt + CW'(1);
        end
    end

    // Completed-frame counter, wraps naturally at 16 bits.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt <= '0;
        end else if (w_h_wrap && w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
        end
    end

    // Swap handshake: a request seen on the ack cycle re-arms pending for the next frame.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_front   <= 1'b0;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_swap;
            if (w_swap) begin
                r_front   <= ~r_front;
                r_pending <= 1'b0;
            end else if (swap_req) begin
                r_pending <= 1'b1;
            end
        end
    end

    generate
        if (SYNC_DLY == 0) begin : g_sync_direct
            assign hs = w_hs_raw;
            assign vs = w_vs_raw;
        end else begin : g_sync_dly
            logic [SYNC_DLY-1:0] r_hs_pipe;
            logic [SYNC_DLY-1:0] r_vs_pipe;

            // Stage 0 takes the raw sync; the oldest stage drives the pin.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_hs_pipe <= '1;
                    r_vs_pipe <= '1;
                end else begin
                    r_hs_pipe <= SYNC_DLY'({r_hs_pipe, w_hs_raw});
                    r_vs_pipe <= SYNC_DLY'({r_vs_pipe, w_vs_raw});
                end
            end

            assign hs = r_hs_pipe[SYNC_DLY-1];
            assign vs = r_vs_pipe[SYNC_DLY-1];
        end
    endgenerate

    assign DrawX        = r_hcnt;
    assign DrawY        = r_vcnt;
    assign blank        = (r_hcnt < CW'(H_ACTIVE)) && (r_vcnt < CW'(V_ACTIVE));
    assign vblank_start = w_vblank_start;
    assign frame_count  = r_frame_cnt;
    assign front_buf    = r_front;
    assign swap_ack     = r_ack;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one full-size instance plus three short-frame
// instances (6 lines) with SYNC_DLY 0, 1 and 3, checked against a cycle-index model.
`timescale 1ns/1ps
module tb_vga_timing_gen;
    localparam int NI = 4;
    localparam int FR = 4800;   // cycles per short frame

    logic vga_clk = 1'b0;
    logic reset_n;
    logic swap_req;

    logic [9:0]  dx   [NI];
    logic [9:0]  dy   [NI];
    logic        bl   [NI];
    logic        hs_o [NI];
    logic        vs_o [NI];
    logic        vbs  [NI];
    logic [15:0] fc   [NI];
    logic        fb   [NI];
    logic        ack  [NI];

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    logic m_front [NI];
    logic m_pend  [NI];
    logic m_ack   [NI];

    always #20 vga_clk = ~vga_clk;

    vga_timing_gen #(.SYNC_DLY(1)) u_full (
        .vga_clk(vga_clk), .reset_n(reset_n), .swap_req(swap_req),
        .DrawX(dx[0]), .DrawY(dy[0]), .blank(bl[0]), .hs(hs_o[0]), .vs(vs_o[0]),
        .vblank_start(vbs[0]), .frame_count(fc[0]), .front_buf(fb[0]), .swap_ack(ack[0]));
    vga_timing_gen #(.SYNC_DLY(0), .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_END(4), .V_TOTAL(6)) u_s0 (
        .vga_clk(vga_clk), .reset_n(reset_n), .swap_req(swap_req),
        .DrawX(dx[1]), .DrawY(dy[1]), .blank(bl[1]), .hs(hs_o[1]), .vs(vs_o[1]),
        .vblank_start(vbs[1]), .frame_count(fc[1]), .front_buf(fb[1]), .swap_ack(ack[1]));
    vga_timing_gen #(.SYNC_DLY(1), .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_END(4), .V_TOTAL(6)) u_s1 (
        .vga_clk(vga_clk), .reset_n(reset_n), .swap_req(swap_req),
        .DrawX(dx[2]), .DrawY(dy[2]), .blank(bl[2]), .hs(hs_o[2]), .vs(vs_o[2]),
        .vblank_start(vbs[2]), .frame_count(fc[2]), .front_buf(fb[2]), .swap_ack(ack[2]));
    vga_timing_gen #(.SYNC_DLY(3), .V_ACTIVE(2), .V_SYNC_START(3), .V_SYNC_END(4), .V_TOTAL(6)) u_s3 (
        .vga_clk(vga_clk), .reset_n(reset_n), .swap_req(swap_req),
        .DrawX(dx[3]), .DrawY(dy[3]), .blank(bl[3]), .hs(hs_o[3]), .vs(vs_o[3]),
        .vblank_start(vbs[3]), .frame_count(fc[3]), .front_buf(fb[3]), .swap_ack(ack[3]));

    // Reference model: every output is a function of the cycle index t since reset release.
    function automatic int vt_of(int k);  return (k == 0) ? 525 : 6; endfunction
    function automatic int va_of(int k);  return (k == 0) ? 480 : 2; endfunction
    function automatic int vss_of(int k); return (k == 0) ? 490 : 3; endfunction
    function automatic int vse_of(int k); return (k == 0) ? 491 : 4; endfunction
    function automatic int dly_of(int k); return (k == 1) ? 0 : ((k == 3) ? 3 : 1); endfunction

    function automatic logic [9:0] ex_x(int tt);
        return 10'(tt % 800);
    endfunction
    function automatic logic [9:0] ex_y(int k, int tt);
        return 10'((tt / 800) % vt_of(k));
    endfunction
    function automatic logic ex_blank(int k, int tt);
        return ((tt % 800) < 640) && (((tt / 800) % vt_of(k)) < va_of(k));
    endfunction
    function automatic logic ex_hs(int k, int tt);
        int u;
        if (tt < dly_of(k)) return 1'b1;
        u = (tt - dly_of(k)) % 800;
        return !(u >= 656 && u <= 751);
    endfunction
    function automatic logic ex_vs(int k, int tt);
        int u;
        if (tt < dly_of(k)) return 1'b1;
        u = ((tt - dly_of(k)) / 800) % vt_of(k);
        return !(u >= vss_of(k) && u <= vse_of(k));
    endfunction
    function automatic logic ex_vbs(int k, int tt);
        return ((tt % 800) == 0) && (((tt / 800) % vt_of(k)) == va_of(k));
    endfunction
    function automatic logic [15:0] ex_fc(int k, int tt);
        return 16'(tt / (800 * vt_of(k)));
    endfunction

    // Drive swap_req for the current cycle, advance the swap model, move to the next negedge.
    task automatic tick(input logic req);
        swap_req = req;
        for (int k = 0; k < NI; k++) begin
            if (ex_vbs(k, t) && (m_pend[k] || req)) begin
                m_front[k] = !m_front[k];
                m_pend[k]  = 1'b0;
                m_ack[k]   = 1'b1;
            end else begin
                if (req) m_pend[k] = 1'b1;
                m_ack[k] = 1'b0;
            end
        end
        @(posedge vga_clk);
        t++;
        @(negedge vga_clk);
    endtask

    task automatic reset_assert();
        swap_req = 1'b0;
        reset_n  = 1'b0;
        #1;
    endtask

    task automatic reset_release(input int n);
        repeat (n) @(negedge vga_clk);
        reset_n = 1'b1;
        t = 0;
        for (int k = 0; k < NI; k++) begin
            m_front[k] = 1'b0;
            m_pend[k]  = 1'b0;
            m_ack[k]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        swap_req = 1'b0;
        reset_n  = 1'b0;
        repeat (2) @(negedge vga_clk);
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (dx[k] !== 10'd0 || dy[k] !== 10'd0) begin
                failures++;
                $display("FAIL reset_counters inst%0d: got (%0d,%0d) want (0,0)", k, dx[k], dy[k]);
            end
            checks++;
            if ({bl[k], hs_o[k], vs_o[k], vbs[k]} !== 4'b1110) begin
                failures++;
                $display("FAIL reset_blank_sync inst%0d: got %b want 1110", k, {bl[k], hs_o[k], vs_o[k], vbs[k]});
            end
            checks++;
            if ({fc[k], fb[k], ack[k]} !== 18'd0) begin
                failures++;
                $display("FAIL reset_frame_swap inst%0d: got fc=%0d fb=%b ack=%b want 0", k, fc[k], fb[k], ack[k]);
            end
        end
        reset_release(1);
        checks++;
        if (dx[0] !== 10'd0) begin
            failures++;
            $display("FAIL hold_before_first_edge: got DrawX=%0d want 0", dx[0]);
        end
        tick(1'b0);
        checks++;
        if (dx[0] !== 10'd1 || dy[0] !== 10'd0) begin
            failures++;
            $display("FAIL first_advance: got (%0d,%0d) want (1,0)", dx[0], dy[0]);
        end
    endtask

    task automatic test_line_timing();
        int err = 0;
        string first = "";
        int hs_low = 0, hs_first = -1, hs_last = -1, blank_first = -1;
        for (int n = 0; n < 1600; n++) begin
            tick(1'b0);
            for (int k = 0; k < NI; k++) begin
                if (dx[k] !== ex_x(t) || dy[k] !== ex_y(k, t) || bl[k] !== ex_blank(k, t) ||
                    hs_o[k] !== ex_hs(k, t) || vs_o[k] !== ex_vs(k, t)) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got x=%0d y=%0d b=%b hs=%b vs=%b want x=%0d y=%0d b=%b hs=%b vs=%b",
                            k, t, dx[k], dy[k], bl[k], hs_o[k], vs_o[k],
                            ex_x(t), ex_y(k, t), ex_blank(k, t), ex_hs(k, t), ex_vs(k, t));
                end
            end
            if (hs_o[0] === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(dx[0]);
                hs_last = int'(dx[0]);
            end
            if (bl[0] === 1'b0 && blank_first < 0) blank_first = int'(dx[0]);
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL line_timing: %0d bad cycles, first %s", err, first);
        end
        checks++;
        if (hs_first != 657 || hs_last != 752 || hs_low != 192) begin
            failures++;
            $display("FAIL hs_window: got first=%0d last=%0d low=%0d want 657 752 192", hs_first, hs_last, hs_low);
        end
        checks++;
        if (blank_first != 640) begin
            failures++;
            $display("FAIL blank_edge: got DrawX=%0d want 640", blank_first);
        end
        checks++;
        if (dx[0] !== 10'd1 || dy[0] !== 10'd2) begin
            failures++;
            $display("FAIL line_period: got (%0d,%0d) want (1,2)", dx[0], dy[0]);
        end
    endtask

    task automatic test_frame_timing();
        int err = 0;
        string first = "";
        int vs_low = 0, vb_cnt = 0;
        int hs_fall [NI];
        int vs_fall [NI];
        for (int k = 0; k < NI; k++) begin
            hs_fall[k] = -1;
            vs_fall[k] = -1;
        end
        @(negedge vga_clk);
        reset_assert();
        reset_release(2);
        for (int n = 0; n < FR; n++) begin
            tick(1'b0);
            for (int k = 1; k < NI; k++) begin
                if (dx[k] !== ex_x(t) || dy[k] !== ex_y(k, t) || bl[k] !== ex_blank(k, t) ||
                    hs_o[k] !== ex_hs(k, t) || vs_o[k] !== ex_vs(k, t) ||
                    vbs[k] !== ex_vbs(k, t) || fc[k] !== ex_fc(k, t)) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got x=%0d y=%0d hs=%b vs=%b vbs=%b fc=%0d want x=%0d y=%0d hs=%b vs=%b vbs=%b fc=%0d",
                            k, t, dx[k], dy[k], hs_o[k], vs_o[k], vbs[k], fc[k],
                            ex_x(t), ex_y(k, t), ex_hs(k, t), ex_vs(k, t), ex_vbs(k, t), ex_fc(k, t));
                end
                if (hs_o[k] === 1'b0 && hs_fall[k] < 0) hs_fall[k] = t;
                if (vs_o[k] === 1'b0 && vs_fall[k] < 0) vs_fall[k] = t;
            end
            if (vs_o[2] === 1'b0) vs_low++;
            if (vbs[2] === 1'b1) vb_cnt++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL frame_timing: %0d bad cycles, first %s", err, first);
        end
        checks++;
        if (vs_low != 1600 || vb_cnt != 1) begin
            failures++;
            $display("FAIL vs_vblank_count: got vs_low=%0d vblank=%0d want 1600 1", vs_low, vb_cnt);
        end
        for (int k = 1; k < NI; k++) begin
            checks++;
            if (hs_fall[k] != 656 + dly_of(k) || vs_fall[k] != 2400 + dly_of(k)) begin
                failures++;
                $display("FAIL sync_delay inst%0d: got hs@%0d vs@%0d want hs@%0d vs@%0d",
                    k, hs_fall[k], vs_fall[k], 656 + dly_of(k), 2400 + dly_of(k));
            end
            checks++;
            if (dx[k] !== 10'd0 || dy[k] !== 10'd0 || fc[k] !== 16'd1) begin
                failures++;
                $display("FAIL frame_wrap inst%0d: got (%0d,%0d) fc=%0d want (0,0) fc=1", k, dx[k], dy[k], fc[k]);
            end
        end
    endtask

    task automatic test_swap();
        int err = 0;
        string first = "";
        logic done = 1'b0, prev_fb, fb_vb = 1'bx, fb_after = 1'bx;
        int tog = 0, acks = 0, tog_f = 0, acks_f = 0, ack_x = -1, ack_y = -1;
        prev_fb = fb[2];
        while (t < 2 * FR + 1610) begin
            tick((t >= FR + 800) && !done);
            for (int k = 1; k < NI; k++) begin
                if (fb[k] !== m_front[k] || ack[k] !== m_ack[k]) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got fb=%b ack=%b want fb=%b ack=%b",
                            k, t, fb[k], ack[k], m_front[k], m_ack[k]);
                end
            end
            if (fb[2] !== prev_fb) begin
                tog++;
                if (t <= 2 * FR) tog_f++;
            end
            prev_fb = fb[2];
            if (ack[2] === 1'b1) begin
                acks++;
                if (t <= 2 * FR) acks_f++;
                if (!done) begin
                    done  = 1'b1;
                    ack_x = int'(dx[2]);
                    ack_y = int'(dy[2]);
                end
            end
            if (t == FR + 1600) fb_vb = fb[2];
            if (t == FR + 1601) fb_after = fb[2];
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL swap_model: %0d bad cycles, first %s", err, first);
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL swap_ack_timeout: got no ack want ack within bound");
        end
        checks++;
        if (ack_x != 1 || ack_y != 2) begin
            failures++;
            $display("FAIL swap_ack_pos: got (%0d,%0d) want (1,2)", ack_x, ack_y);
        end
        checks++;
        if (fb_vb !== 1'b0 || fb_after !== 1'b1) begin
            failures++;
            $display("FAIL swap_toggle: got fb %b->%b want 0->1", fb_vb, fb_after);
        end
        checks++;
        if (tog_f != 1 || acks_f != 1 || tog != 1 || acks != 1) begin
            failures++;
            $display("FAIL swap_single: got tog=%0d/%0d acks=%0d/%0d want 1/1 1/1", tog_f, tog, acks_f, acks);
        end
    endtask

    task automatic test_random_swap();
        int err = 0;
        string first = "";
        int acks = 0, m_acks = 0, cur_f = -1, cur_tog = 0, max_tog = 0;
        logic prev_fb;
        prev_fb = fb[2];
        for (int n = 0; n < 2 * FR; n++) begin
            tick($urandom_range(0, 7) == 0);
            for (int k = 1; k < NI; k++) begin
                if (fb[k] !== m_front[k] || ack[k] !== m_ack[k]) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got fb=%b ack=%b want fb=%b ack=%b",
                            k, t, fb[k], ack[k], m_front[k], m_ack[k]);
                end
            end
            if ((t - 1) / FR != cur_f) begin
                cur_f   = (t - 1) / FR;
                cur_tog = 0;
            end
            if (fb[2] !== prev_fb) cur_tog++;
            if (cur_tog > max_tog) max_tog = cur_tog;
            prev_fb = fb[2];
            if (ack[2] === 1'b1) acks++;
            if (m_ack[2]) m_acks++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL random_swap: %0d bad cycles, first %s", err, first);
        end
        checks++;
        if (max_tog > 1 || acks != m_acks) begin
            failures++;
            $display("FAIL random_swap_rate: got max_tog=%0d acks=%0d want <=1 acks=%0d", max_tog, acks, m_acks);
        end
    endtask

    task automatic test_late_request();
        int err = 0;
        string first = "";
        int tog = 0, acks = 0, first_tog = -1;
        logic prev_fb;
        reset_assert();
        reset_release(2);
        while (t != 4 * 800) tick(1'b0);
        prev_fb = fb[2];
        for (int n = 0; n < 3 * FR; n++) begin
            tick(1'b1);
            for (int k = 1; k < NI; k++) begin
                if (fb[k] !== m_front[k] || ack[k] !== m_ack[k]) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got fb=%b ack=%b want fb=%b ack=%b",
                            k, t, fb[k], ack[k], m_front[k], m_ack[k]);
                end
            end
            if (fb[2] !== prev_fb) begin
                tog++;
                if (first_tog < 0) first_tog = t;
            end
            prev_fb = fb[2];
            if (ack[2] === 1'b1) acks++;
        end
        checks++;
        if (err != 0) begin
            failures++;
            $display("FAIL late_model: %0d bad cycles, first %s", err, first);
        end
        checks++;
        if (first_tog != FR + 1601) begin
            failures++;
            $display("FAIL late_first_toggle: got t=%0d want t=%0d", first_tog, FR + 1601);
        end
        checks++;
        if (tog != 3 || acks != 3) begin
            failures++;
            $display("FAIL held_req_3_frames: got toggles=%0d acks=%0d want 3 3", tog, acks);
        end
    endtask

    task automatic test_reset_mid();
        int err = 0;
        string first = "";
        int acks = 0;
        while (((t / 800) % 6) != 1 || (t % 800) != 0) tick(1'b0);
        tick(1'b1);
        repeat (10) tick(1'b0);
        reset_assert();
        for (int k = 1; k < NI; k++) begin
            checks++;
            if (dx[k] !== 10'd0 || dy[k] !== 10'd0 || bl[k] !== 1'b1) begin
                failures++;
                $display("FAIL midreset_counters inst%0d: got (%0d,%0d) b=%b want (0,0) b=1", k, dx[k], dy[k], bl[k]);
            end
            checks++;
            if ({hs_o[k], vs_o[k], vbs[k]} !== 3'b110) begin
                failures++;
                $display("FAIL midreset_sync inst%0d: got %b want 110", k, {hs_o[k], vs_o[k], vbs[k]});
            end
            checks++;
            if ({fc[k], fb[k], ack[k]} !== 18'd0) begin
                failures++;
                $display("FAIL midreset_swap inst%0d: got fc=%0d fb=%b ack=%b want 0", k, fc[k], fb[k], ack[k]);
            end
        end
        reset_release(3);
        for (int n = 0; n < FR + 2; n++) begin
            tick(1'b0);
            for (int k = 1; k < NI; k++) begin
                if (fb[k] !== m_front[k] || ack[k] !== m_ack[k] || fc[k] !== ex_fc(k, t)) begin
                    err++;
                    if (first == "")
                        first = $sformatf("inst%0d t=%0d got fb=%b ack=%b fc=%0d want fb=%b ack=%b fc=%0d",
                            k, t, fb[k], ack[k], fc[k], m_front[k], m_ack[k], ex_fc(k, t));
                end
            end
            if (ack[2] === 1'b1) acks++;
            if (t == 1601) begin
                checks++;
                if (fb[2] !== 1'b0 || fc[2] !== 16'd0) begin
                    failures++;
                    $display("FAIL midreset_no_swap: got fb=%b fc=%0d want fb=0 fc=0", fb[2], fc[2]);
                end
            end
        end
        checks++;
        if (err != 0 || acks != 0) begin
            failures++;
            $display("FAIL midreset_after: %0d bad cycles, acks=%0d want 0, first %s", err, acks, first);
        end
    endtask

    initial begin
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_swap();
        test_random_swap();
        test_late_request();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
